// File: rtl/vga_rom_scanout_if.sv
// ROM read port and VGA DAC pin bundle shared between the scanout engine
// (master) and the ROM/DAC side (slave).
interface vga_rom_scanout_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [7:0]            vga_r;
    logic [7:0]            vga_g;
    logic [7:0]            vga_b;
    logic                  vga_hs;
    logic                  vga_vs;
    logic                  vga_de;

    modport master (
        output rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
        input  rom_q
    );

    modport slave (
        input  rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
        output rom_q
    );
endinterface

// File: rtl/vga_rom_scanout.sv
// VGA timing generator that scans a low-res image ROM, upscaled by
// 2^SCALE_SHIFT in both axes, out to RGB888 with delay-matched syncs.
module vga_rom_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int IMG_W       = 160,
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 24,
    parameter int CLK_DIV     = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_rom_scanout_if.master bus,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt,
    output logic              frame_start
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SUB_C  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic [9:0]             h_cnt_q, h_cnt_d;
    logic [9:0]             v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
    logic [SCALE_SHIFT-1:0] line_sub_q, line_sub_d;
    logic [DATA_WIDTH-1:0]  rgb_q, rgb_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   frame_start_q, frame_start_d;

    logic pix_en;
    logic active;
    logic h_wrap;
    logic v_wrap;

    assign pix_en = (div_q == DIV_LAST_C);
    assign active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign h_wrap = (h_cnt_q == H_LAST_C);
    assign v_wrap = (v_cnt_q == V_LAST_C);

    // Row base is accumulated per source row, so the address needs only an add.
    assign bus.rom_addr = active ? (row_base_q + ADDR_WIDTH'(h_cnt_q >> SCALE_SHIFT)) : '0;

    always_comb begin
        div_d         = pix_en ? '0 : div_q + DIV_W'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        row_base_d    = row_base_q;
        line_sub_d    = line_sub_q;
        rgb_d         = rgb_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            // Output stage samples the pre-advance counters: one pixel of latency.
            de_d  = active;
            hs_d  = !((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C));
            vs_d  = !((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C));
            rgb_d = active ? bus.rom_q : '0;

            if (h_wrap) begin
                h_cnt_d = '0;
                if (v_wrap) begin
                    v_cnt_d       = '0;
                    row_base_d    = '0;
                    line_sub_d    = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                    if (v_cnt_q < V_SUB_C) begin
                        line_sub_d = line_sub_q + SCALE_SHIFT'(1);
                        if (&line_sub_q) begin
                            row_base_d = row_base_q + ADDR_WIDTH'(IMG_W);
                        end
                    end
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            row_base_q    <= '0;
            line_sub_q    <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_base_q    <= row_base_d;
            line_sub_q    <= line_sub_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.vga_r  = rgb_q[23:16];
    assign bus.vga_g  = rgb_q[15:8];
    assign bus.vga_b  = rgb_q[7:0];
    assign bus.vga_de = de_q;
    assign bus.vga_hs = hs_q;
    assign bus.vga_vs = vs_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign frame_start = frame_start_q;
endmodule
